// File: rtl/v_instr_queue.sv
// Issue queue between the scalar core and the vector coprocessor: buffers instructions with
// their scalar operands and presents one at a time, holding it stable until it completes.
module v_instr_queue #(
   parameter int unsigned DEPTH          = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [31:0]             in_instr,
   input  logic [31:0]             in_rs1_data,
   input  logic [31:0]             in_rs2_data,
   output logic [31:0]             op_instr_base,
   output logic [31:0]             xreg_out1,
   output logic [31:0]             xreg_out2,
   input  logic                    v_done,
   output logic                    busy,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    timeout_err
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] rs1;
      logic [31:0] rs2;
   } entry_t;

   typedef enum logic {IDLE, EXEC} state_e;

   state_e             state_q, state_d;
   entry_t             mem_q [DEPTH];
   entry_t             head_c;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic [31:0]        op_q, op_d, x1_q, x1_d, x2_q, x2_d;
   logic               terr_q, terr_d;
   logic               push_c, pop_c, done_c, tmo_c, vcfg_c;

   assign in_ready      = (count_q != CNT_W'(DEPTH));
   assign push_c        = in_valid & in_ready & ~flush;
   assign vcfg_c        = (op_q[6:0] == 7'b1010111) && (op_q[14:12] == 3'b111);
   assign tmo_c         = (state_q == EXEC) && !v_done && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
   assign done_c        = (state_q == EXEC) && (vcfg_c || v_done || tmo_c);
   assign pop_c         = done_c & ~flush;
   assign head_c        = mem_q[rd_ptr_q];

   assign op_instr_base = op_q;
   assign xreg_out1     = x1_q;
   assign xreg_out2     = x2_q;
   assign busy          = (state_q == EXEC);
   assign count         = count_q;
   assign timeout_err   = terr_q;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (count_q != '0) state_d = EXEC;
            EXEC:    if (done_c)        state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Output/datapath next values; completion zeroes the outputs to force a one-cycle bubble
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      timer_d  = timer_q;
      op_d     = op_q;
      x1_d     = x1_q;
      x2_d     = x2_q;
      terr_d   = terr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         timer_d  = '0;
         op_d     = '0;
         x1_d     = '0;
         x2_d     = '0;
         terr_d   = 1'b0;
      end else begin
         if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
         case (state_q)
            IDLE: begin
               if (count_q != '0) begin
                  op_d    = head_c.instr;
                  x1_d    = head_c.rs1;
                  x2_d    = head_c.rs2;
                  timer_d = '0;
               end
            end
            EXEC: begin
               if (done_c) begin
                  op_d    = '0;
                  x1_d    = '0;
                  x2_d    = '0;
                  timer_d = '0;
                  if (tmo_c) terr_d = 1'b1;
               end else begin
                  timer_d = timer_q + TMR_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         timer_q  <= '0;
         op_q     <= '0;
         x1_q     <= '0;
         x2_q     <= '0;
         terr_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         timer_q  <= timer_d;
         op_q     <= op_d;
         x1_q     <= x1_d;
         x2_q     <= x2_d;
         terr_q   <= terr_d;
      end
   end

   // Entry storage needs no reset; only slots behind a valid count are ever read
   always_ff @(posedge clk) begin
      if (push_c) mem_q[wr_ptr_q] <= '{instr: in_instr, rs1: in_rs1_data, rs2: in_rs2_data};
   end

endmodule

// File: tb/tb_v_instr_queue.sv
// Directed bench for v_instr_queue: table of single-cycle vectors plus hand-written
// sequences for full-queue wrap, timeout, async reset and flush.
module tb_v_instr_queue;

   localparam logic [31:0] VADD = 32'h02208057;
   localparam logic [31:0] VSET = 32'h0D007057;
   localparam logic [31:0] IA   = 32'h00000057;
   localparam logic [31:0] IB   = 32'h12345057;

   logic        clk, rst, flush, in_valid, in_ready, v_done, busy, timeout_err;
   logic [31:0] in_instr, in_rs1_data, in_rs2_data, op_instr_base, xreg_out1, xreg_out2;
   logic [2:0]  count;

   int checks   = 0;
   int failures = 0;

   v_instr_queue #(.DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
      .op_instr_base(op_instr_base), .xreg_out1(xreg_out1), .xreg_out2(xreg_out2),
      .v_done(v_done), .busy(busy), .count(count), .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        fl, vld;
      logic [31:0] instr, rs1, rs2;
      logic        vd;
      logic [31:0] e_op, e_x1, e_x2;
      logic        e_busy, e_rdy;
      logic [2:0]  e_cnt;
      logic        e_terr;
   } vec_t;

   vec_t vecs [18];

   function automatic vec_t mk(input logic vld, input logic [31:0] instr, rs1, rs2,
                               input logic vd, input logic [31:0] e_op, e_x1, e_x2,
                               input logic e_busy, input logic [2:0] e_cnt);
      vec_t v;
      v = '{fl: 1'b0, vld: vld, instr: instr, rs1: rs1, rs2: rs2, vd: vd,
            e_op: e_op, e_x1: e_x1, e_x2: e_x2, e_busy: e_busy, e_rdy: 1'b1,
            e_cnt: e_cnt, e_terr: 1'b0};
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic vld, input logic [31:0] instr, rs1, rs2, input logic vd);
      in_valid = vld; in_instr = instr; in_rs1_data = rs1; in_rs2_data = rs2; v_done = vd;
   endtask

   task automatic chk_state(input string nm, input logic [31:0] e_op, input logic e_busy,
                            input logic [2:0] e_cnt, input logic e_rdy, input logic e_terr);
      chk({nm, ".op"},    op_instr_base, e_op);
      chk({nm, ".busy"},  32'(busy),        32'(e_busy));
      chk({nm, ".count"}, 32'(count),       32'(e_cnt));
      chk({nm, ".ready"}, 32'(in_ready),    32'(e_rdy));
      chk({nm, ".terr"},  32'(timeout_err), 32'(e_terr));
   endtask

   initial begin
      logic [31:0] qi [5];

      rst = 1'b1; flush = 1'b0;
      drive(1'b0, '0, '0, '0, 1'b0);

      // Single-step vectors: inputs for one edge, outputs expected just after it
      vecs[0]  = mk(1, VADD, 32'h11, 32'h22, 0, 0,    0,     0,     0, 1);
      vecs[1]  = mk(0, 0,    0,      0,      0, VADD, 32'h11, 32'h22, 1, 1);
      vecs[2]  = vecs[1];
      vecs[3]  = vecs[1];
      vecs[4]  = vecs[1];
      vecs[5]  = vecs[1];
      vecs[6]  = mk(0, 0,    0,      0,      1, 0,    0,     0,     0, 0);
      vecs[7]  = mk(0, 0,    0,      0,      1, 0,    0,     0,     0, 0);
      vecs[8]  = mk(1, VSET, 32'h5,  32'h6,  0, 0,    0,     0,     0, 1);
      vecs[9]  = mk(1, VADD, 32'h33, 32'h44, 0, VSET, 32'h5, 32'h6, 1, 2);
      vecs[10] = mk(0, 0,    0,      0,      0, 0,    0,     0,     0, 1);
      vecs[11] = mk(0, 0,    0,      0,      0, VADD, 32'h33, 32'h44, 1, 1);
      vecs[12] = mk(0, 0,    0,      0,      1, 0,    0,     0,     0, 0);
      vecs[13] = mk(1, IA,   32'h1,  32'h2,  0, 0,    0,     0,     0, 1);
      vecs[14] = mk(0, 0,    0,      0,      0, IA,   32'h1, 32'h2, 1, 1);
      vecs[15] = mk(1, IB,   32'h3,  32'h4,  1, 0,    0,     0,     0, 1);
      vecs[16] = mk(0, 0,    0,      0,      0, IB,   32'h3, 32'h4, 1, 1);
      vecs[17] = mk(0, 0,    0,      0,      1, 0,    0,     0,     0, 0);

      #12;
      chk_state("reset", 32'h0, 1'b0, 3'd0, 1'b1, 1'b0);
      @(negedge clk); rst = 1'b0;

      for (int i = 0; i < 18; i++) begin
         flush = vecs[i].fl;
         drive(vecs[i].vld, vecs[i].instr, vecs[i].rs1, vecs[i].rs2, vecs[i].vd);
         step();
         chk_state($sformatf("vec%0d", i), vecs[i].e_op, vecs[i].e_busy, vecs[i].e_cnt,
                   vecs[i].e_rdy, vecs[i].e_terr);
         chk($sformatf("vec%0d.x1", i), xreg_out1, vecs[i].e_x1);
         chk($sformatf("vec%0d.x2", i), xreg_out2, vecs[i].e_x2);
      end

      // Full queue: fifth push held until a slot frees, order kept across pointer wrap
      for (int j = 0; j < 5; j++) qi[j] = 32'h02000057 | (32'(j) << 15);
      for (int j = 0; j < 4; j++) begin
         drive(1'b1, qi[j], 32'(j), 32'(j + 100), 1'b0);
         step();
      end
      chk_state("full", qi[0], 1'b1, 3'd4, 1'b0, 1'b0);
      drive(1'b1, qi[4], 32'd4, 32'd104, 1'b0);
      step();
      chk_state("full_hold", qi[0], 1'b1, 3'd4, 1'b0, 1'b0);
      drive(1'b1, qi[4], 32'd4, 32'd104, 1'b1);
      step();
      chk_state("full_pop", 32'h0, 1'b0, 3'd3, 1'b1, 1'b0);
      drive(1'b1, qi[4], 32'd4, 32'd104, 1'b0);
      step();
      chk_state("fifth_in", qi[1], 1'b1, 3'd4, 1'b0, 1'b0);
      drive(1'b0, '0, '0, '0, 1'b0);
      for (int j = 1; j < 5; j++) begin
         chk($sformatf("order%0d.op", j), op_instr_base, qi[j]);
         chk($sformatf("order%0d.x1", j), xreg_out1, 32'(j));
         chk($sformatf("order%0d.x2", j), xreg_out2, 32'(j + 100));
         v_done = 1'b1; step();
         v_done = 1'b0; step();
      end
      chk_state("drained", 32'h0, 1'b0, 3'd0, 1'b1, 1'b0);

      // Timeout after 16 EXEC cycles with no v_done
      drive(1'b1, VADD, 32'h7, 32'h8, 1'b0);
      step();
      drive(1'b0, '0, '0, '0, 1'b0);
      step();
      chk_state("tmo_start", VADD, 1'b1, 3'd1, 1'b1, 1'b0);
      for (int j = 0; j < 15; j++) step();
      chk_state("tmo_last", VADD, 1'b1, 3'd1, 1'b1, 1'b0);
      step();
      chk_state("tmo_fire", 32'h0, 1'b0, 3'd0, 1'b1, 1'b1);

      // Asynchronous reset while an instruction executes
      drive(1'b1, IA, 32'h9, 32'hA, 1'b0);
      step();
      drive(1'b0, '0, '0, '0, 1'b0);
      step();
      chk_state("pre_rst", IA, 1'b1, 3'd1, 1'b1, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk_state("async_rst", 32'h0, 1'b0, 3'd0, 1'b1, 1'b0);
      chk("async_rst.x1", xreg_out1, 32'h0);
      @(negedge clk); rst = 1'b0;

      // Flush with three queued (one executing) and a simultaneous push
      for (int j = 0; j < 3; j++) begin
         drive(1'b1, qi[j], 32'(j), 32'(j), 1'b0);
         step();
      end
      chk_state("pre_flush", qi[0], 1'b1, 3'd3, 1'b1, 1'b0);
      flush = 1'b1;
      drive(1'b1, qi[3], 32'd3, 32'd3, 1'b0);
      step();
      flush = 1'b0;
      drive(1'b0, '0, '0, '0, 1'b0);
      chk_state("flush", 32'h0, 1'b0, 3'd0, 1'b1, 1'b0);
      step();
      chk_state("flush_drop", 32'h0, 1'b0, 3'd0, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
